// File: rtl/spram_ctrl_pkg.sv
// Shared encodings and widths for the single-port SPRAM arbiter.
// Read-tag layout travels with each read through the SPRAM latency pipeline.
package spram_ctrl_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam int MASK_W = 4;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_SLEEP = 2'd1;
    localparam logic [1:0] ST_WAKE  = 2'd2;

    typedef struct packed {
        logic vld;
        logic port;
    } rd_tag_t;

endpackage

// File: rtl/spram_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, on contention the port
// that did not win last time is chosen.
module spram_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Two-port round-robin front end for one SB_SPRAM256KA with fixed 3-cycle
// read latency and idle-driven SLEEP / on-demand wake.
module spram_arbiter
    import spram_ctrl_pkg::*;
#(
    parameter int SLEEP_IDLE  = 256,
    parameter int WAKE_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [MASK_W-1:0] mask0,
    input  logic [MASK_W-1:0] mask1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] spram_addr,
    output logic [DATA_W-1:0] spram_din,
    output logic [MASK_W-1:0] spram_mask,
    output logic              spram_wren,
    output logic              spram_cs,
    output logic              spram_sleep,
    input  logic [DATA_W-1:0] spram_dout
);

    localparam int CNT_MAX = (SLEEP_IDLE > WAKE_CYCLES) ? SLEEP_IDLE : WAKE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [1:0]        state_q, state_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    rd_tag_t           tag_p0_q, tag_p0_d, tag_p1_q, tag_p1_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic              wren_q, wren_d;
    logic              cs_q, cs_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic [1:0]        pick;
    logic [1:0]        gnt;
    logic              run;
    logic              any_req;
    logic              pipe_busy;
    logic              win;
    logic              we_w;
    logic [MASK_W-1:0] mask_w;

    spram_rr_pick u_pick (
        .req  ({req1, req0}),
        .last (last_q),
        .gnt  (pick)
    );

    // Grants are suppressed while RST is high so every output reads 0 in reset.
    assign run       = (state_q == ST_RUN) && !RST;
    assign gnt       = run ? pick : 2'b00;
    assign any_req   = req0 | req1;
    assign pipe_busy = tag_p0_q.vld | tag_p1_q.vld;
    assign win       = gnt[1];
    assign we_w      = win ? we1 : we0;
    assign mask_w    = win ? mask1 : mask0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (any_req || pipe_busy || SLEEP_IDLE == 0) begin
                    cnt_d = '0;
                end else if (int'(cnt_q) == SLEEP_IDLE - 1) begin
                    state_d = ST_SLEEP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SLEEP: begin
                cnt_d = '0;
                if (any_req) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (int'(cnt_q) >= WAKE_CYCLES - 1) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        last_d        = last_q;
        addr_d        = addr_q;
        din_d         = din_q;
        mask_d        = '0;
        wren_d        = 1'b0;
        cs_d          = 1'b0;
        tag_p0_d      = '0;
        if (|gnt) begin
            last_d        = win;
            addr_d        = win ? addr1 : addr0;
            din_d         = win ? wdata1 : wdata0;
            mask_d        = we_w ? mask_w : '0;
            wren_d        = we_w;
            cs_d          = 1'b1;
            tag_p0_d.vld  = !we_w;
            tag_p0_d.port = win;
        end
        tag_p1_d = tag_p0_q;
    end

    // DATAOUT is valid while the tag sits in the second stage.
    always_comb begin
        rvalid0_d = tag_p1_q.vld && !tag_p1_q.port;
        rvalid1_d = tag_p1_q.vld && tag_p1_q.port;
        rdata0_d  = rvalid0_d ? spram_dout : rdata0_q;
        rdata1_d  = rvalid1_d ? spram_dout : rdata1_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_RUN;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            tag_p0_q  <= '0;
            tag_p1_q  <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            mask_q    <= '0;
            wren_q    <= 1'b0;
            cs_q      <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            tag_p0_q  <= tag_p0_d;
            tag_p1_q  <= tag_p1_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            mask_q    <= mask_d;
            wren_q    <= wren_d;
            cs_q      <= cs_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    assign gnt0        = gnt[0];
    assign gnt1        = gnt[1];
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign busy        = (state_q == ST_WAKE) | pipe_busy;
    assign spram_addr  = addr_q;
    assign spram_din   = din_q;
    assign spram_mask  = mask_q;
    assign spram_wren  = wren_q;
    assign spram_cs    = cs_q;
    assign spram_sleep = (state_q == ST_SLEEP);

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural SPRAM attached.
module tb_spram_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [13:0] addr0 = 0, addr1 = 0;
    logic [15:0] wdata0 = 0, wdata1 = 0;
    logic [3:0]  mask0 = 0, mask1 = 0;
    logic        gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [15:0] rdata0, rdata1;
    logic [13:0] spram_addr;
    logic [15:0] spram_din;
    logic [3:0]  spram_mask;
    logic        spram_wren, spram_cs, spram_sleep;
    logic [15:0] spram_dout = 16'h0;

    logic [15:0] mem [0:16383];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    spram_arbiter #(.SLEEP_IDLE(8), .WAKE_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .mask0(mask0), .mask1(mask1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .spram_addr(spram_addr), .spram_din(spram_din), .spram_mask(spram_mask),
        .spram_wren(spram_wren), .spram_cs(spram_cs), .spram_sleep(spram_sleep),
        .spram_dout(spram_dout)
    );

    // SB_SPRAM256KA behaviour: samples at the edge, nibble-masked writes.
    always @(posedge CLK) begin
        if (spram_cs && !spram_sleep) begin
            if (spram_wren) begin
                for (int i = 0; i < 4; i++)
                    if (spram_mask[i]) mem[spram_addr][4*i +: 4] <= spram_din[4*i +: 4];
            end else begin
                spram_dout <= mem[spram_addr];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    logic        sv0 [0:23];
    logic        sv1 [0:23];
    logic [15:0] sd0 [0:23];
    logic [15:0] sd1 [0:23];
    int          c0, c1, nrv0, nrv1;
    logic        exp_w;

    initial begin
        // Reset state
        repeat (2) drive_cycle();
        sample();
        check_eq("rst_ctl", {gnt0, gnt1, rvalid0, rvalid1, busy, spram_wren, spram_cs, spram_sleep}, 0);
        check_eq("rst_data", {rdata0, rdata1}, 0);
        check_eq("rst_spram", {spram_addr, spram_din, spram_mask}, 0);
        drive_cycle();
        RST = 0;

        // Write 0x0001 @0, then read it back on port 0
        drive_cycle();
        req0 = 1; we0 = 1; addr0 = 14'h0; wdata0 = 16'h0001; mask0 = 4'hF;
        sample();
        check_eq("t1_wr_gnt", {gnt1, gnt0}, 2'b01);
        drive_cycle();
        we0 = 0;
        sample();
        check_eq("t1_rd_gnt", gnt0, 1);
        check_eq("t1_wr_bus", {spram_cs, spram_wren, spram_mask, spram_addr, spram_din}, {1'b1, 1'b1, 4'hF, 14'h0, 16'h0001});
        drive_cycle();
        req0 = 0;
        sample();
        check_eq("t1_rd_bus", {spram_cs, spram_wren, spram_mask, busy, rvalid0}, {1'b1, 1'b0, 4'h0, 1'b1, 1'b0});
        drive_cycle();
        sample();
        check_eq("t1_rv_t2", rvalid0, 0);
        drive_cycle();
        sample();
        check_eq("t1_rv_t3", {rvalid0, rdata0}, {1'b1, 16'h0001});
        drive_cycle();
        sample();
        check_eq("t1_hold", {rvalid0, rdata0, busy}, {1'b0, 16'h0001, 1'b0});

        // Preload 0x10.. and 0x20.. through port 0
        for (int i = 0; i < 16; i++) begin
            drive_cycle();
            req0 = 1; we0 = 1; mask0 = 4'hF;
            addr0  = (i < 8) ? 14'h10 + 14'(i) : 14'h20 + 14'(i - 8);
            wdata0 = (i < 8) ? 16'hA000 + 16'(i) : 16'hB000 + 16'(i - 8);
            sample();
            if (i == 0 || i == 15) check_eq("pre_gnt0", gnt0, 1);
        end

        // Both ports read every cycle: port 1 wins first since port 0 won last
        for (int k = 0; k < 24; k++) begin
            sv0[k] = 0; sv1[k] = 0; sd0[k] = 0; sd1[k] = 0;
        end
        c0 = 0; c1 = 0; nrv0 = 0; nrv1 = 0;
        for (int k = 0; k < 20; k++) begin
            drive_cycle();
            if (k < 16) begin
                req0 = 1; req1 = 1; we0 = 0; we1 = 0;
                addr0 = 14'h10 + 14'(c0);
                addr1 = 14'h20 + 14'(c1);
            end else begin
                req0 = 0; req1 = 0;
            end
            sample();
            if (k < 16) begin
                exp_w = (k % 2 == 0);
                check_eq("alt_gnt", {gnt1, gnt0}, exp_w ? 2'b10 : 2'b01);
                if (exp_w) begin
                    sv1[k+3] = 1; sd1[k+3] = 16'hB000 + 16'(c1); c1++;
                end else begin
                    sv0[k+3] = 1; sd0[k+3] = 16'hA000 + 16'(c0); c0++;
                end
            end
            if (rvalid0) nrv0++;
            if (rvalid1) nrv1++;
            check_eq("alt_rv", {rvalid1, rvalid0}, {sv1[k], sv0[k]});
            if (sv0[k]) check_eq("alt_rd0", rdata0, sd0[k]);
            if (sv1[k]) check_eq("alt_rd1", rdata1, sd1[k]);
        end
        check_eq("alt_cnt", {nrv1[7:0], nrv0[7:0]}, {8'd8, 8'd8});

        // Masked write: 0xFFFF then mask 0011 with 0x1234 -> 0xFF34
        drive_cycle();
        req1 = 1; we1 = 1; addr1 = 14'h55; wdata1 = 16'hFFFF; mask1 = 4'hF;
        sample();
        check_eq("mk_gnt", gnt1, 1);
        drive_cycle();
        wdata1 = 16'h1234; mask1 = 4'b0011;
        sample();
        check_eq("mk_bus1", spram_mask, 4'hF);
        drive_cycle();
        we1 = 0;
        sample();
        check_eq("mk_bus2", {spram_wren, spram_mask, spram_din}, {1'b1, 4'b0011, 16'h1234});
        drive_cycle();
        req1 = 0;
        sample();
        check_eq("mk_rdbus", {spram_cs, spram_wren, spram_mask}, {1'b1, 1'b0, 4'h0});
        drive_cycle();
        sample();
        drive_cycle();
        sample();
        check_eq("mk_read", {rvalid1, rdata1}, {1'b1, 16'hFF34});

        // Read of 0x3FFF followed by a write to it returns the old content
        drive_cycle();
        req0 = 1; we0 = 1; addr0 = 14'h3FFF; wdata0 = 16'h5A5A; mask0 = 4'hF;
        sample();
        drive_cycle();
        req0 = 0; req1 = 1; we1 = 0; addr1 = 14'h3FFF;
        sample();
        check_eq("raw_rgnt", {gnt1, gnt0}, 2'b10);
        drive_cycle();
        req1 = 0; req0 = 1; we0 = 1; wdata0 = 16'hC3C3;
        sample();
        check_eq("raw_wgnt", {gnt1, gnt0}, 2'b01);
        drive_cycle();
        req0 = 0; req1 = 1;
        sample();
        drive_cycle();
        req1 = 0;
        sample();
        check_eq("raw_old", {rvalid1, rdata1}, {1'b1, 16'h5A5A});
        drive_cycle();
        sample();
        check_eq("raw_gap", rvalid1, 0);
        drive_cycle();
        sample();
        check_eq("raw_new", {rvalid1, rdata1}, {1'b1, 16'hC3C3});

        // Sleep after 8 idle cycles, wake on req1, data intact
        drive_cycle();
        RST = 1;
        drive_cycle();
        RST = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge CLK);
            sample();
            if (i == 7) check_eq("slp_early", spram_sleep, 0);
            if (i == 8) check_eq("slp_on", {spram_sleep, spram_cs, busy}, 3'b100);
        end
        drive_cycle();
        req1 = 1; we1 = 0; addr1 = 14'h55;
        sample();
        check_eq("slp_req", {gnt1, spram_sleep}, 2'b01);
        for (int i = 1; i <= 5; i++) begin
            drive_cycle();
            sample();
            if (i < 5) check_eq("wake", {gnt1, spram_sleep, busy}, 3'b001);
            else       check_eq("wake_gnt", {gnt1, spram_sleep}, 2'b10);
        end
        drive_cycle();
        req1 = 0;
        sample();
        drive_cycle();
        sample();
        check_eq("wake_rv2", rvalid1, 0);
        drive_cycle();
        sample();
        check_eq("wake_data", {rvalid1, rdata1}, {1'b1, 16'hFF34});

        // Asynchronous reset one cycle after a read grant
        drive_cycle();
        req0 = 1; we0 = 0; addr0 = 14'h0;
        sample();
        check_eq("ar_gnt", gnt0, 1);
        drive_cycle();
        req0 = 0;
        #1;
        check_eq("ar_pre", {busy, spram_cs}, 2'b11);
        #1;
        RST = 1;
        #1;
        check_eq("ar_ctl", {gnt0, gnt1, rvalid0, rvalid1, busy, spram_wren, spram_cs, spram_sleep}, 0);
        check_eq("ar_data", {rdata0, rdata1, spram_addr}, 0);
        drive_cycle();
        drive_cycle();
        RST = 0;
        for (int i = 0; i < 4; i++) begin
            sample();
            check_eq("ar_norv", {rvalid0, rdata0}, 0);
            drive_cycle();
        end

        // After reset port 0 wins a simultaneous request, then port 1
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 14'h10; addr1 = 14'h20;
        sample();
        check_eq("prio_first", {gnt1, gnt0}, 2'b01);
        drive_cycle();
        sample();
        check_eq("prio_second", {gnt1, gnt0}, 2'b10);
        drive_cycle();
        req0 = 0; req1 = 0;
        repeat (4) drive_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
